// File: rtl/servant_loader_pkg.sv
// rtl/servant_loader_pkg.sv - shared state encoding and constants for the servant boot loader
package servant_loader_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        COLLECT = ST_COLLECT,
        WRITE   = ST_WRITE
    } state_t;

    localparam int LANES = 4;

endpackage

// File: rtl/servant_loader.sv
// rtl/servant_loader.sv - packs a boot byte stream into 32-bit words and writes them to RAM over Wishbone
module servant_loader
    import servant_loader_pkg::*;
#(
    parameter int depth = 256,
    parameter int aw    = $clog2(depth)
) (
    input  logic          i_wb_clk,
    input  logic          i_wb_rst,
    input  logic          i_start,
    input  logic [7:0]    i_byte,
    input  logic          i_byte_valid,
    input  logic          i_byte_last,
    output logic          o_byte_ready,
    output logic [aw-3:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_cyc,
    input  logic          i_wb_ack,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [aw-2:0] o_words
);

    localparam logic [aw-3:0] ADR_MAX = (aw-2)'(depth/LANES - 1);

    state_t      state, state_nxt;
    logic [1:0]  lane;
    logic        last_seen;
    logic        accept;
    logic        at_end;

    assign o_byte_ready = (state == COLLECT);
    assign o_wb_we      = (state == WRITE);
    assign accept       = o_byte_ready && i_byte_valid;
    assign at_end       = (o_wb_adr == ADR_MAX);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_start) state_nxt = COLLECT;
            end
            COLLECT: begin
                if (accept && (lane == 2'd3 || i_byte_last)) state_nxt = WRITE;
            end
            WRITE: begin
                if (i_wb_ack) state_nxt = (last_seen || at_end) ? IDLE : COLLECT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state     <= IDLE;
            lane      <= 2'd0;
            last_seen <= 1'b0;
            o_wb_adr  <= '0;
            o_wb_dat  <= '0;
            o_wb_sel  <= '0;
            o_wb_cyc  <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            o_words   <= '0;
        end else begin
            state    <= state_nxt;
            o_wb_cyc <= (state_nxt == WRITE);
            o_busy   <= (state_nxt != IDLE);
            o_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        lane      <= 2'd0;
                        last_seen <= 1'b0;
                        o_wb_adr  <= '0;
                        o_wb_dat  <= '0;
                        o_wb_sel  <= '0;
                        o_err     <= 1'b0;
                        o_words   <= '0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        o_wb_dat[{lane, 3'b000} +: 8] <= i_byte;
                        o_wb_sel[lane]                <= 1'b1;
                        lane                          <= lane + 2'd1;
                        last_seen                     <= i_byte_last;
                    end
                end
                WRITE: begin
                    if (i_wb_ack) begin
                        o_words  <= o_words + (aw-1)'(1);
                        o_wb_dat <= '0;
                        o_wb_sel <= '0;
                        lane     <= 2'd0;
                        // the address saturates at the top word; running past it is an overflow
                        if (last_seen) begin
                            o_done <= 1'b1;
                        end else if (at_end) begin
                            o_err  <= 1'b1;
                            o_done <= 1'b1;
                        end else begin
                            o_wb_adr <= o_wb_adr + (aw-2)'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/servant_loader.md
# servant_loader

Wishbone initiator that fills the servant program RAM from a byte stream (UART or SPI boot path). It assembles incoming bytes little-endian into 32-bit words and issues one Wishbone write per word to sequential word addresses starting at 0. It holds the CPU in reset while loading and reports completion or overflow. It connects to the same Wishbone write port as the CPU data bus, through the existing arbiter, and is the write-side counterpart of the RAM's responder.

## Interface
Parameters:
- depth, 256: RAM size in bytes; must match the target RAM.
- aw, $clog2(depth): byte-address width.

Ports:
- i_wb_clk  in  1  clock; all logic is on the rising edge.
- i_wb_rst  in  1  synchronous, active-high reset.
- i_start  in  1  starts a load at word address 0; ignored while o_busy.
- i_byte  in  8  stream data.
- i_byte_valid  in  1  stream valid.
- i_byte_last  in  1  marks the final byte of the image; qualified by i_byte_valid.
- o_byte_ready  out  1  stream ready.
- o_wb_adr  out  aw-2  word address; bits [aw-1:2].
- o_wb_dat  out  32  write data.
- o_wb_sel  out  4  byte enables.
- o_wb_we  out  1  write enable; equals o_wb_cyc.
- o_wb_cyc  out  1  cycle request.
- i_wb_ack  in  1  responder ack.
- o_busy  out  1  load in progress; also drives the CPU reset.
- o_done  out  1  one-cycle pulse when a load ends, whether by success or error.
- o_err  out  1  overflow flag; sticky until the next accepted i_start or reset.
- o_words  out  aw-1  count of words written in the current or last load.

## Operation
- The FSM has three states: IDLE, COLLECT and WRITE.
- IDLE:
  - On i_start: clear o_words, o_err, the byte lane index and the address, then go to COLLECT.
- COLLECT:
  - o_byte_ready=1.
  - An accepted byte (valid&ready) at lane k (0..3) goes to o_wb_dat[8k+7:8k] and sets o_wb_sel[k].
  - Go to WRITE after lane 3 is accepted, or after any lane accepted with i_byte_last.
- WRITE:
  - o_byte_ready=0; o_wb_cyc=o_wb_we=1. Adr, dat and sel are stable until ack.
  - On i_wb_ack: cyc drops the next cycle, o_words increments, dat and sel clear to 0, lane resets to 0.
    - If the word held the last byte: pulse o_done and go to IDLE.
    - Else if o_wb_adr == depth/4-1: set o_err, pulse o_done and go to IDLE. The address does not wrap.
    - Else increment o_wb_adr and return to COLLECT.
- A partial final word writes only the accepted lanes. Unused lanes have sel=0 and dat=0.
- i_byte_last on lane 3 causes exactly one write, with no extra empty word.
- i_start while busy has no effect. i_byte_valid in IDLE is not accepted (ready=0).
- o_busy=1 in COLLECT and WRITE.

## Timing
- Reset values:
  - state IDLE.
  - o_wb_cyc, o_wb_we, o_byte_ready, o_busy, o_done, o_err all 0.
  - o_wb_adr, o_wb_dat, o_wb_sel, o_words all 0.
- All outputs are registered except o_byte_ready and o_wb_we, which decode directly from the state register.
- i_start at edge N puts the block in COLLECT (ready=1) from N+1.
- Fourth byte accepted at edge M: cyc=1 from M+1.
- Against the RAM (ack registered one cycle after cyc):
  - ack is seen at edge M+2; cyc=0 and ready=1 from M+2.
  - Throughput is 4 bytes per 6 cycles.
- The block tolerates arbitrary ack delay. Cyc is never dropped before ack.
- The block never asserts cyc in the cycle immediately after an ack, because the responder's ack toggles.
- o_done pulses in the cycle after the final ack edge, coincident with o_busy falling.
- Reset mid-operation returns everything to reset values the next cycle, cyc included. Any partial word is discarded.

## Structure
- Put the state encoding (IDLE/COLLECT/WRITE) in the shared servant package as a localparam set.
- No sub-module: the byte packer and the FSM share the lane counter and stay in one module.

## Test plan
- Load 8 bytes 0x11..0x18, last on 0x18:
  - writes adr0 dat=0x14131211 sel=0xF, then adr1 dat=0x18171615 sel=0xF.
  - o_words=2, one o_done pulse, o_err=0.
- Load 5 bytes 0xA0..0xA4, last on 0xA4:
  - second write adr1 dat=0x000000A4 sel=0x1.
  - RAM readback of word1 keeps the other three bytes' prior contents.
- depth=16, 20 bytes without last:
  - 4 writes at adr 0..3, then o_err=1 and o_done pulses.
  - No fifth cycle; ready=0 afterwards.
- Responder with ack delayed 5 cycles:
  - cyc held with stable adr, dat and sel until ack; no bytes accepted during WRITE.
- i_wb_rst asserted during WRITE of word 2:
  - next cycle cyc=0, o_busy=0, o_words=0.
  - A subsequent i_start restarts at adr 0.
- i_start pulsed mid-load and i_byte_valid asserted in IDLE:
  - neither has any effect; the address sequence is unchanged.
